axi_lite_mem_master: RTL and testbench

//  AXI4-Lite initiator that turns a CPU-side single-beat load/store request into AXI-Lite read or write transactions.

---
 rtl/axi_lite_mem_master_pkg.sv | 26 ++
 rtl/axi_lite_mem_master.sv | 207 ++++++++++++++++++++
 tb/tb_axi_lite_mem_master.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_mem_master_pkg.sv
// Shared definitions for the AXI4-Lite memory master: widths, response codes, FSM states.
package axi_lite_mem_master_pkg;

    localparam int unsigned CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_D  = 3'd2,
        ST_WR_AW = 3'd3,
        ST_WR_B  = 3'd4
    } state_e;

    // Any response other than OKAY is reported to the CPU as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_mem_master.sv
// AXI4-Lite initiator: one CPU load/store at a time mapped onto AXI-Lite read/write transactions.
module axi_lite_mem_master
    import axi_lite_mem_master_pkg::*;
#(
    parameter int unsigned      DATA_W    = CPU_WIDTH,
    parameter int unsigned      TMO_W     = 16,
    parameter logic [TMO_W-1:0] TMO_LIMIT = '1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    // CPU request / response
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wen,
    input  logic [DATA_W-1:0]     i_req_addr,
    input  logic [DATA_W-1:0]     i_req_wdata,
    input  logic [DATA_W/8-1:0]   i_req_wstrb,
    output logic                  o_rsp_valid,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_timeout,
    // AXI4-Lite write address / data / response
    output logic [DATA_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    // AXI4-Lite read address / data
    output logic [DATA_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e              state, state_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [STRB_W-1:0]   wstrb_d;
    logic                aw_done, aw_done_d;
    logic                w_done, w_done_d;
    logic                req_ready_d;
    logic                awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic                rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic                aw_hs, w_hs, aw_done_n, w_done_n;
    logic [TMO_W-1:0]    tmo_cnt;

    // Both address channels carry the single latched request address.
    assign awaddr = addr_q;
    assign araddr = addr_q;

    // State and all registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            wdata       <= '0;
            wstrb       <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            o_req_ready <= 1'b1;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            state       <= state_d;
            addr_q      <= addr_d;
            wdata       <= wdata_d;
            wstrb       <= wstrb_d;
            aw_done     <= aw_done_d;
            w_done      <= w_done_d;
            o_req_ready <= req_ready_d;
            awvalid     <= awvalid_d;
            wvalid      <= wvalid_d;
            bready      <= bready_d;
            arvalid     <= arvalid_d;
            rready      <= rready_d;
            o_rsp_valid <= rsp_valid_d;
            o_rsp_rdata <= rsp_rdata_d;
            o_rsp_err   <= rsp_err_d;
        end
    end

    // Next-state and next-output logic; valids only ever change on a completed handshake.
    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        wdata_d     = wdata;
        wstrb_d     = wstrb;
        aw_done_d   = aw_done;
        w_done_d    = w_done;
        req_ready_d = o_req_ready;
        awvalid_d   = awvalid;
        wvalid_d    = wvalid;
        bready_d    = bready;
        arvalid_d   = arvalid;
        rready_d    = rready;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = o_rsp_rdata;
        rsp_err_d   = o_rsp_err;

        aw_hs     = awvalid & awready;
        w_hs      = wvalid & wready;
        aw_done_n = aw_done | aw_hs;
        w_done_n  = w_done | w_hs;

        case (state)
            ST_IDLE: begin
                if (i_req_valid && o_req_ready) begin
                    addr_d      = i_req_addr;
                    wdata_d     = i_req_wdata;
                    wstrb_d     = i_req_wstrb;
                    req_ready_d = 1'b0;
                    if (i_req_wen) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR_AW;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_A;
                    end
                end
            end
            ST_RD_A: begin
                if (arvalid && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_D;
                end
            end
            ST_RD_D: begin
                if (rvalid && rready) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rdata;
                    rsp_err_d   = resp_is_err(rresp);
                    rready_d    = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_WR_AW: begin
                aw_done_d = aw_done_n;
                w_done_d  = w_done_n;
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (aw_done_n && w_done_n) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (bvalid && bready) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = resp_is_err(bresp);
                    bready_d    = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
            end
        endcase
    end

    // Watchdog: counts busy cycles per transaction; flags a stuck slave without aborting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt   <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (state != ST_IDLE && tmo_cnt == TMO_LIMIT) begin
                o_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Directed bench for axi_lite_mem_master with a cycle-stepped AXI-Lite slave model.
module tb_axi_lite_mem_master;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_valid, o_req_ready, i_req_wen;
    logic [DW-1:0] i_req_addr, i_req_wdata;
    logic [SW-1:0] i_req_wstrb;
    logic          o_rsp_valid, o_rsp_err, o_timeout;
    logic [DW-1:0] o_rsp_rdata;
    logic [DW-1:0] awaddr, wdata, araddr, rdata;
    logic [SW-1:0] wstrb;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    axi_lite_mem_master #(
        .DATA_W   (DW),
        .TMO_W    (16),
        .TMO_LIMIT(16'd8)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_wen  (i_req_wen),
        .i_req_addr (i_req_addr),
        .i_req_wdata(i_req_wdata),
        .i_req_wstrb(i_req_wstrb),
        .o_rsp_valid(o_rsp_valid),
        .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_err  (o_rsp_err),
        .o_timeout  (o_timeout),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready)
    );

    typedef struct {
        logic          wen;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Request driver state
    req_t          rq[$];
    int            rq_idx;
    bit            acc_q;
    int            n_acc;
    logic [DW-1:0] cur_addr, cur_wdata;
    logic [SW-1:0] cur_wstrb;

    // Slave configuration
    int            ar_dly, aw_dly, w_dly;
    bit            ar_never;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp, s_bresp;

    // Slave and monitor state
    int            ar_cnt, aw_cnt, w_cnt;
    bit            ar_hs_q, r_hs_q, aw_hs_q, w_hs_q, b_hs_q, aw_seen, w_seen;
    int            n_b_hs, n_rsp, viol_addr, viol_aw, viol_bready;
    logic [DW-1:0] rsp_rdata_q[$];
    logic          rsp_err_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_bench();
        rq.delete();
        rq_idx = 0; acc_q = 0; n_acc = 0;
        cur_addr = '0; cur_wdata = '0; cur_wstrb = '0;
        ar_dly = 0; aw_dly = 0; w_dly = 0; ar_never = 0;
        s_rdata = '0; s_rresp = 2'b00; s_bresp = 2'b00;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        ar_hs_q = 0; r_hs_q = 0; aw_hs_q = 0; w_hs_q = 0; b_hs_q = 0;
        aw_seen = 0; w_seen = 0;
        n_b_hs = 0; n_rsp = 0; viol_addr = 0; viol_aw = 0; viol_bready = 0;
        rsp_rdata_q.delete(); rsp_err_q.delete();
        i_req_valid = 0; i_req_wen = 0; i_req_addr = '0; i_req_wdata = '0; i_req_wstrb = '0;
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; bresp = 2'b00; rvalid = 0; rdata = '0; rresp = 2'b00;
    endtask

    // One clock cycle: observe what the last posedge did, then drive the next cycle's inputs.
    task automatic step();
        req_t r;
        @(negedge clk);
        if (acc_q) begin
            r = rq[rq_idx];
            cur_addr = r.addr; cur_wdata = r.wdata; cur_wstrb = r.wstrb;
            rq_idx++; n_acc++;
        end
        if (rq_idx < rq.size()) begin
            r = rq[rq_idx];
            i_req_valid = 1'b1;
            i_req_wen = r.wen; i_req_addr = r.addr; i_req_wdata = r.wdata; i_req_wstrb = r.wstrb;
        end else begin
            // Scramble the CPU side so only latched copies can reach the bus.
            i_req_valid = 1'b0;
            i_req_wen = 1'($urandom); i_req_addr = $urandom; i_req_wdata = $urandom;
            i_req_wstrb = SW'($urandom);
        end
        acc_q = i_req_valid && o_req_ready;

        if (o_rsp_valid) begin
            n_rsp++;
            rsp_rdata_q.push_back(o_rsp_rdata);
            rsp_err_q.push_back(o_rsp_err);
        end
        if (arvalid && araddr !== cur_addr) viol_addr++;
        if (awvalid && awaddr !== cur_addr) viol_addr++;
        if (wvalid && (wdata !== cur_wdata || wstrb !== cur_wstrb)) viol_addr++;

        if (r_hs_q) rvalid = 1'b0;
        if (b_hs_q) bvalid = 1'b0;
        if (ar_hs_q) begin rvalid = 1'b1; rdata = s_rdata; rresp = s_rresp; end
        if (aw_hs_q) aw_seen = 1;
        if (w_hs_q)  w_seen = 1;
        if (aw_seen && !w_seen && awvalid) viol_aw++;
        if (bready && !(aw_seen && w_seen)) viol_bready++;
        if (aw_seen && w_seen) begin
            bvalid = 1'b1; bresp = s_bresp; aw_seen = 0; w_seen = 0;
        end

        arready = arvalid && !ar_never && (ar_cnt >= ar_dly);
        if (arvalid && !arready) ar_cnt++; else ar_cnt = 0;
        awready = awvalid && (aw_cnt >= aw_dly);
        if (awvalid && !awready) aw_cnt++; else aw_cnt = 0;
        wready = wvalid && (w_cnt >= w_dly);
        if (wvalid && !wready) w_cnt++; else w_cnt = 0;

        ar_hs_q = arvalid && arready;
        r_hs_q  = rvalid && rready;
        aw_hs_q = awvalid && awready;
        w_hs_q  = wvalid && wready;
        b_hs_q  = bvalid && bready;
        if (b_hs_q) n_b_hs++;
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && n_rsp < target; i++) step();
        check(tag, 32'(n_rsp), 32'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_bench();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        clear_bench();
        do_reset();
        check("rst_req_ready", 32'(o_req_ready), 32'd1);
        check("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
        check("rst_rsp", 32'({o_rsp_valid, o_rsp_err, o_timeout}), 32'd0);
        check("rst_addr", araddr, 32'd0);

        // Read with arready one cycle late
        clear_bench();
        ar_dly = 1; s_rdata = 32'h1234_5678; s_rresp = 2'b00;
        rq.push_back('{1'b0, 32'ha000_2000, 32'h0, 4'h0});
        run_until("rd1_done", 1, 40);
        repeat (4) step();
        check("rd1_pulses", 32'(n_rsp), 32'd1);
        check("rd1_rdata", o_rsp_rdata, 32'h1234_5678);
        check("rd1_err", 32'(o_rsp_err), 32'd0);
        check("rd1_addr_hold", 32'(viol_addr), 32'd0);
        check("rd1_accepts", 32'(n_acc), 32'd1);

        // Write, aw channel completes three cycles ahead of w
        clear_bench();
        aw_dly = 0; w_dly = 3; s_bresp = 2'b00;
        rq.push_back('{1'b1, 32'h8000_0010, 32'hdead_beef, 4'b0011});
        run_until("wr2_done", 1, 40);
        repeat (3) step();
        check("wr2_pulses", 32'(n_rsp), 32'd1);
        check("wr2_rdata", o_rsp_rdata, 32'd0);
        check("wr2_err", 32'(o_rsp_err), 32'd0);
        check("wr2_aw_drop", 32'(viol_aw), 32'd0);
        check("wr2_bready", 32'(viol_bready), 32'd0);
        check("wr2_payload", 32'(viol_addr), 32'd0);
        check("wr2_b_hs", 32'(n_b_hs), 32'd1);

        // Read answered with DECERR
        clear_bench();
        s_rdata = 32'hcafe_f00d; s_rresp = 2'b11;
        rq.push_back('{1'b0, 32'h4000_0004, 32'h0, 4'h0});
        run_until("rd3_done", 1, 40);
        check("rd3_rdata", o_rsp_rdata, 32'hcafe_f00d);
        check("rd3_err", 32'(o_rsp_err), 32'd1);
        step();
        check("rd3_ready_again", 32'(o_req_ready), 32'd1);

        // Back-to-back read/write/read, zero-wait slave, request valid held high
        clear_bench();
        s_rdata = 32'h0bad_cafe;
        rq.push_back('{1'b0, 32'h0000_1000, 32'h0, 4'h0});
        rq.push_back('{1'b1, 32'h0000_1004, 32'h5555_aaaa, 4'hf});
        rq.push_back('{1'b0, 32'h0000_1008, 32'h0, 4'h0});
        run_until("b2b_done", 3, 100);
        repeat (4) step();
        check("b2b_accepts", 32'(n_acc), 32'd3);
        check("b2b_pulses", 32'(n_rsp), 32'd3);
        check("b2b_payload", 32'(viol_addr), 32'd0);
        check("b2b_timeout", 32'(o_timeout), 32'd0);
        if (rsp_rdata_q.size() == 3) begin
            check("b2b_rd0", rsp_rdata_q[0], 32'h0bad_cafe);
            check("b2b_wr1", rsp_rdata_q[1], 32'd0);
            check("b2b_rd2", rsp_rdata_q[2], 32'h0bad_cafe);
            check("b2b_errs", 32'({rsp_err_q[0], rsp_err_q[1], rsp_err_q[2]}), 32'd0);
        end

        // Slave never answers the read address: watchdog fires, transaction stays up
        clear_bench();
        ar_never = 1;
        rq.push_back('{1'b0, 32'h0200_bff8, 32'h0, 4'h0});
        rq.push_back('{1'b0, 32'h0200_4000, 32'h0, 4'h0});
        repeat (5) step();
        check("tmo_early", 32'(o_timeout), 32'd0);
        repeat (12) step();
        check("tmo_set", 32'(o_timeout), 32'd1);
        check("tmo_arvalid", 32'(arvalid), 32'd1);
        check("tmo_req_ready", 32'(o_req_ready), 32'd0);
        check("tmo_accepts", 32'(n_acc), 32'd1);
        repeat (3) step();
        check("tmo_sticky", 32'(o_timeout), 32'd1);

        do_reset();
        check("tmo_cleared", 32'(o_timeout), 32'd0);

        // Reset asserted while the write channels are still pending
        clear_bench();
        aw_dly = 1000; w_dly = 1000;
        rq.push_back('{1'b1, 32'h1000_0000, 32'h0000_0041, 4'h1});
        repeat (4) step();
        check("rstmid_pre", 32'({awvalid, wvalid}), 32'b11);
        #2 rst = 1'b1;
        #1;
        check("rstmid_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
        check("rstmid_rsp", 32'(o_rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_bench();
        step();
        check("rstmid_ready", 32'(o_req_ready), 32'd1);
        check("rstmid_idle", 32'({awvalid, wvalid}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
